// File: rtl/serial_frame_receiver.sv
// Deserializes the 66-bit readout frame (header, NUM_CH channel words, trailer); fields and frame_valid appear 1 sclk after the last bit.
// No backpressure: a new frame overwrites an unacknowledged one and sets overrun. `define TRAILER_CHECK_EN rejects frames whose trailer != TRAILER_PATTERN.
module serial_frame_receiver #(
   parameter int NUM_CH   = 8,
   parameter int CH_BITS  = 7,
   parameter int HDR_BITS = 4,
   parameter int TRL_BITS = 6,
   parameter logic [TRL_BITS-1:0] TRAILER_PATTERN = 6'b101010
) (
   input  logic                       sclk,
   input  logic                       rst,
   input  logic                       serial_in,
   input  logic                       frame_start,
   input  logic                       frame_ack,
   input  logic                       overrun_clr,
   output logic [7:0]                 bit_addr,
   output logic                       busy,
   output logic [HDR_BITS-1:0]        hdr_data,
   output logic [NUM_CH*CH_BITS-1:0]  ch_data,
   output logic [TRL_BITS-1:0]        trl_data,
   output logic                       frame_valid,
   output logic                       frame_err,
   output logic                       overrun
);

   localparam int DATA_BITS  = NUM_CH * CH_BITS;
   localparam int FRAME_BITS = HDR_BITS + DATA_BITS + TRL_BITS;
   localparam logic [7:0] HDR_LAST  = 8'(HDR_BITS - 1);
   localparam logic [7:0] DATA_LAST = 8'(HDR_BITS + DATA_BITS - 1);
   localparam logic [7:0] FRM_LAST  = 8'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_TRL,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [7:0]            r_cnt;
   logic [7:0]            w_cnt_nxt;
   logic                  w_cap;
   logic                  w_abort;
   logic                  w_done;

   logic [HDR_BITS-1:0]   r_hdr_sh;
   logic [DATA_BITS-1:0]  r_ch_sh;
   logic [TRL_BITS-1:0]   r_trl_sh;
   logic [DATA_BITS-1:0]  w_ch_unpack;

   logic [HDR_BITS-1:0]   r_hdr_q;
   logic [DATA_BITS-1:0]  r_ch_q;
   logic [TRL_BITS-1:0]   r_trl_q;
   logic                  r_valid;
   logic                  r_err;
   logic                  r_overrun;

   logic                  w_cap_hdr;
   logic                  w_cap_ch;
   logic                  w_cap_trl;
   logic                  w_trl_ok;
   logic                  w_commit;

   // r_cnt always holds the address of the most recently captured bit
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap       = 1'b0;
      w_abort     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_state_nxt = S_HDR;
               w_cnt_nxt   = 8'd0;
               w_cap       = 1'b1;
            end
         end
         S_HDR, S_DATA, S_TRL: begin
            if (frame_start) begin
               w_abort     = 1'b1;
               w_state_nxt = S_HDR;
               w_cnt_nxt   = 8'd0;
               w_cap       = 1'b1;
            end else if (r_state == S_TRL && r_cnt == FRM_LAST) begin
               w_done      = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_cap     = 1'b1;
               w_cnt_nxt = r_cnt + 8'd1;
               if (r_state == S_HDR && r_cnt == HDR_LAST) begin
                  w_state_nxt = S_DATA;
               end else if (r_state == S_DATA && r_cnt == DATA_LAST) begin
                  w_state_nxt = S_TRL;
               end
            end
         end
         S_DONE: begin
            w_cnt_nxt = 8'd0;
            if (frame_start) begin
               w_state_nxt = S_HDR;
               w_cap       = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   // Route each captured bit to the field that owns its address
   assign w_cap_hdr = w_cap && (w_cnt_nxt <= HDR_LAST);
   assign w_cap_ch  = w_cap && (w_cnt_nxt > HDR_LAST) && (w_cnt_nxt <= DATA_LAST);
   assign w_cap_trl = w_cap && (w_cnt_nxt > DATA_LAST);

   // Channel shift register holds channel 0 at its top; re-pack so channel k sits at [CH_BITS*k +: CH_BITS]
   always_comb begin
      w_ch_unpack = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_ch_unpack[CH_BITS*k +: CH_BITS] = r_ch_sh[DATA_BITS-CH_BITS*(k+1) +: CH_BITS];
      end
   end

`ifdef TRAILER_CHECK_EN
   assign w_trl_ok = (r_trl_sh == TRAILER_PATTERN);
`else
   assign w_trl_ok = 1'b1;
`endif

   assign w_commit = w_done & w_trl_ok;

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_hdr_sh  <= '0;
         r_ch_sh   <= '0;
         r_trl_sh  <= '0;
         r_hdr_q   <= '0;
         r_ch_q    <= '0;
         r_trl_q   <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_cap_hdr) begin
            r_hdr_sh <= {r_hdr_sh[HDR_BITS-2:0], serial_in};
         end
         if (w_cap_ch) begin
            r_ch_sh <= {r_ch_sh[DATA_BITS-2:0], serial_in};
         end
         if (w_cap_trl) begin
            r_trl_sh <= {r_trl_sh[TRL_BITS-2:0], serial_in};
         end

         r_err <= w_abort | (w_done & ~w_trl_ok);

         if (w_commit) begin
            r_hdr_q <= r_hdr_sh;
            r_ch_q  <= w_ch_unpack;
            r_trl_q <= r_trl_sh;
         end

         // A new frame beats a same-cycle ack, so valid stays up
         if (w_commit) begin
            r_valid <= 1'b1;
         end else if (frame_ack) begin
            r_valid <= 1'b0;
         end

         if (w_commit && r_valid && !frame_ack) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign bit_addr    = r_cnt;
   assign busy        = (r_state != S_IDLE);
   assign hdr_data    = r_hdr_q;
   assign ch_data     = r_ch_q;
   assign trl_data    = r_trl_q;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed frames driven on negedge; expected frames are queued and a negedge monitor checks each presented frame.
module tb_serial_frame_receiver;

   logic        sclk = 1'b0;
   logic        rst = 1'b1;
   logic        serial_in = 1'b0;
   logic        frame_start = 1'b0;
   logic        frame_ack = 1'b0;
   logic        overrun_clr = 1'b0;
   logic [7:0]  bit_addr;
   logic        busy;
   logic [3:0]  hdr_data;
   logic [55:0] ch_data;
   logic [5:0]  trl_data;
   logic        frame_valid;
   logic        frame_err;
   logic        overrun;

   serial_frame_receiver dut (
      .sclk        (sclk),
      .rst         (rst),
      .serial_in   (serial_in),
      .frame_start (frame_start),
      .frame_ack   (frame_ack),
      .overrun_clr (overrun_clr),
      .bit_addr    (bit_addr),
      .busy        (busy),
      .hdr_data    (hdr_data),
      .ch_data     (ch_data),
      .trl_data    (trl_data),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   always #5 sclk = ~sclk;

   int unsigned cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  hdr;
      logic [55:0] ch;
      logic [5:0]  trl;
      int unsigned at;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   err_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [65:0] mk(input logic [3:0] h, input logic [55:0] ch, input logic [5:0] t);
      logic [65:0] f;
      f[65:62] = h;
      for (int k = 0; k < 8; k++) f[61-7*k -: 7] = ch[7*k +: 7];
      f[5:0] = t;
      return f;
   endfunction

   // Drives addresses 0..n-1 of a frame; a full frame with push set queues its expected result
   task automatic send(input logic [3:0] h, input logic [55:0] ch, input logic [5:0] t,
                       input int n, input bit push);
      logic [65:0] f;
      f = mk(h, ch, t);
      for (int a = 0; a < n; a++) begin
         @(negedge sclk);
         if (a == 5) begin
            chk("bit_addr_after_addr4", 64'(bit_addr), 64'd4);
            chk("busy_mid_frame", 64'(busy), 64'd1);
         end
         frame_start = (a == 0);
         serial_in   = f[65-a];
         if (a == 65 && push) sb.push_back('{h, ch, t, cyc + 2});
      end
   endtask

   task automatic finish_and_ack();
      @(negedge sclk);
      frame_start = 1'b0;
      chk("bit_addr_after_last", 64'(bit_addr), 64'd65);
      chk("valid_not_early", 64'(frame_valid), 64'd0);
      @(negedge sclk);
      chk("valid_after_1_sclk", 64'(frame_valid), 64'd1);
      frame_ack = 1'b1;
      @(negedge sclk);
      frame_ack = 1'b0;
      chk("ack_drops_valid", 64'(frame_valid), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bit_addr"}, 64'(bit_addr), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_hdr"}, 64'(hdr_data), 64'd0);
      chk({tag, "_ch"}, 64'(ch_data), 64'd0);
      chk({tag, "_trl"}, 64'(trl_data), 64'd0);
      chk({tag, "_valid"}, 64'(frame_valid), 64'd0);
      chk({tag, "_err"}, 64'(frame_err), 64'd0);
      chk({tag, "_overrun"}, 64'(overrun), 64'd0);
   endtask

   // Monitor: a frame is presented when valid rises or the held fields change while valid
   initial begin
      logic        p_valid;
      logic [3:0]  p_hdr;
      logic [55:0] p_ch;
      logic [5:0]  p_trl;
      exp_t        e;
      p_valid = 1'b0; p_hdr = '0; p_ch = '0; p_trl = '0;
      forever begin
         @(negedge sclk);
         if (frame_err) err_cycles++;
         if (!rst && frame_valid &&
             (!p_valid || hdr_data != p_hdr || ch_data != p_ch || trl_data != p_trl)) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_hdr", 64'(hdr_data), 64'(e.hdr));
               chk("sb_ch", 64'(ch_data), 64'(e.ch));
               chk("sb_trl", 64'(trl_data), 64'(e.trl));
               chk("sb_latency_cycle", 64'(cyc), 64'(e.at));
            end
         end
         p_valid = frame_valid; p_hdr = hdr_data; p_ch = ch_data; p_trl = trl_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      logic [55:0] ch_a, ch_ramp, ch_b, ch_c, ch_d, ch_e, ch_f, ch_g, ch_h;
      ch_a    = {7'h2A, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h55};
      ch_ramp = {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
      ch_b    = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66, 7'h77, 7'h01};
      ch_c    = {7'h7E, 7'h3C, 7'h18, 7'h00, 7'h7F, 7'h41, 7'h22, 7'h14};
      ch_d    = {8{7'h7F}};
      ch_e    = {7'h12, 7'h34, 7'h56, 7'h78, 7'h1A, 7'h2B, 7'h3C, 7'h4D};
      ch_f    = {8{7'h5A}};
      ch_g    = {7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h03};
      ch_h    = {7'h6B, 7'h00, 7'h19, 7'h00, 7'h2D, 7'h00, 7'h4F, 7'h00};

      repeat (3) @(negedge sclk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Basic frame
      send(4'b1010, ch_a, 6'b101010, 66, 1'b1);
      finish_and_ack();

      // Ramp channels
      send(4'b0110, ch_ramp, 6'b101010, 66, 1'b1);
      finish_and_ack();
      chk("ramp_ch0", 64'(ch_data[6:0]), 64'd1);
      chk("ramp_ch7", 64'(ch_data[55:49]), 64'd8);

      // Back-to-back, start in DONE, no ack in between
      send(4'b1100, ch_b, 6'b101010, 66, 1'b1);
      @(negedge sclk);
      frame_start = 1'b0;
      send(4'b0011, ch_c, 6'b101010, 66, 1'b1);
      @(negedge sclk);
      frame_start = 1'b0;
      @(negedge sclk);
      chk("b2b_valid_held", 64'(frame_valid), 64'd1);
      chk("b2b_overrun_set", 64'(overrun), 64'd1);
      overrun_clr = 1'b1;
      @(negedge sclk);
      overrun_clr = 1'b0;
      chk("overrun_cleared", 64'(overrun), 64'd0);
      frame_ack = 1'b1;
      @(negedge sclk);
      frame_ack = 1'b0;
      chk("b2b_ack_drops_valid", 64'(frame_valid), 64'd0);

      // Restart on the edge that would carry address 30
      e0 = err_cycles;
      send(4'b1111, ch_d, 6'b101010, 30, 1'b0);
      send(4'b0101, ch_e, 6'b101010, 66, 1'b1);
      finish_and_ack();
      chk("abort_err_one_cycle", 64'(err_cycles - e0), 64'd1);

      // Reset after address 39 capture
      e0 = err_cycles;
      send(4'b1001, ch_f, 6'b101010, 40, 1'b0);
      @(negedge sclk);
      frame_start = 1'b0;
      rst = 1'b1;
      @(negedge sclk);
      chk_all_zero("midreset");
      rst = 1'b0;
      chk("reset_no_err", 64'(err_cycles - e0), 64'd0);
      send(4'b0111, ch_g, 6'b101010, 66, 1'b1);
      finish_and_ack();

      // All-zero trailer
      e0 = err_cycles;
`ifdef TRAILER_CHECK_EN
      send(4'b1000, ch_h, 6'b000000, 66, 1'b0);
      @(negedge sclk);
      frame_start = 1'b0;
      repeat (3) @(negedge sclk);
      chk("badtrl_valid_low", 64'(frame_valid), 64'd0);
      chk("badtrl_hdr_kept", 64'(hdr_data), 64'(4'b0111));
      chk("badtrl_ch_kept", 64'(ch_data), 64'(ch_g));
      chk("badtrl_trl_kept", 64'(trl_data), 64'(6'b101010));
      chk("badtrl_err_pulse", 64'(err_cycles - e0), 64'd1);
`else
      send(4'b1000, ch_h, 6'b000000, 66, 1'b1);
      finish_and_ack();
      chk("zerotrl_trl_data", 64'(trl_data), 64'd0);
      chk("zerotrl_no_err", 64'(err_cycles - e0), 64'd0);
`endif
      chk("final_overrun", 64'(overrun), 64'd0);

      repeat (2) @(negedge sclk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
